// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the simpleMIPS multicycle controller.
// Holds the FSM state encoding, instruction field codes, datapath mux
// select encodings and the instruction-class record produced by mc_decode.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   // Opcode and funct fields of the supported subset
   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;

   // PC source select
   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_BR    = 2'd1;
   localparam logic [1:0] PC_JUMP  = 2'd2;

   // ALU operation select
   localparam logic [1:0] ALU_ADD  = 2'd0;
   localparam logic [1:0] ALU_ADDU = 2'd1;
   localparam logic [1:0] ALU_SUBU = 2'd2;
   localparam logic [1:0] ALU_OR   = 2'd3;

   // Register-file write-data select
   localparam logic [1:0] WD_fromALU = 2'd0;
   localparam logic [1:0] WD_fromMEM = 2'd1;
   localparam logic [1:0] WD_fromPC  = 2'd2;

   // Register-file destination select
   localparam logic [1:0] RD_fromRD = 2'd0;
   localparam logic [1:0] RD_fromRT = 2'd1;
   localparam logic [1:0] RD_RA     = 2'd2;

   // Instruction classes consumed by the sequencing FSM
   typedef struct packed {
      logic rtype;
      logic itype;
      logic load;
      logic store;
      logic branch;
      logic jump;
      logic legal;
   } iclass_t;

   // R-type ALU operation chosen from the funct field (addu or subu only)
   function automatic logic [1:0] rtype_alu_op(input logic [5:0] funct);
      return (funct == FUNCT_SUBU) ? ALU_SUBU : ALU_ADDU;
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_decode: purely combinational classifier that maps the instruction
// register onto the instruction classes the mc_ctrl FSM sequences.
// R-type is only legal for the addu and subu funct codes.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output iclass_t     cls
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       unused_instr_bits;

   assign opcode            = instr[31:26];
   assign funct             = instr[5:0];
   assign unused_instr_bits = ^instr[25:6];

   // Classify by opcode; legal is the union of every recognised class
   always_comb begin
      cls = '0;
      case (opcode)
         OP_RTYPE: cls.rtype  = (funct == FUNCT_ADDU) || (funct == FUNCT_SUBU);
         OP_ORI:   cls.itype  = 1'b1;
         OP_LW:    cls.load   = 1'b1;
         OP_SW:    cls.store  = 1'b1;
         OP_BEQ:   cls.branch = 1'b1;
         OP_JAL:   cls.jump   = 1'b1;
         default:  cls        = '0;
      endcase
      cls.legal = cls.rtype | cls.itype | cls.load | cls.store | cls.branch | cls.jump;
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the simpleMIPS
// datapath (addu, subu, ori, lw, sw, beq, jal). Issues one-cycle datapath
// strobes and holds memory requests until the matching ready arrives.
// Optional feature: define MC_PERF_CNT_EN to build the cycle/instruction
// performance counters; otherwise both counter ports are constant 0.
module mc_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        breq,
   input  logic        imem_rdy,
   input  logic        dmem_rdy,
   output logic        imem_req,
   output logic        ir_wr,
   output logic        dmem_req,
   output logic        dm_wr,
   output logic        reg_wr,
   output logic        pc_wr,
   output logic [1:0]  pc_src,
   output logic        bsel,
   output logic [1:0]  alu_op,
   output logic [1:0]  wd_sel,
   output logic [1:0]  rd_sel,
   output logic        illegal,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
);

   state_t  state;
   state_t  next_state;
   iclass_t cls;
   logic    retire;

   mc_decode u_decode (
      .instr (instr),
      .cls   (cls)
   );

   // State register; reset always restarts at instruction fetch
   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= next_state;
   end

   // Next-state and strobe decode; reset masks every strobe and request
   always_comb begin
      next_state = state;
      imem_req   = 1'b0;
      ir_wr      = 1'b0;
      dmem_req   = 1'b0;
      dm_wr      = 1'b0;
      reg_wr     = 1'b0;
      pc_wr      = 1'b0;
      pc_src     = PC_PLUS4;
      bsel       = 1'b0;
      alu_op     = ALU_ADD;
      wd_sel     = WD_fromALU;
      rd_sel     = RD_fromRD;
      illegal    = 1'b0;
      retire     = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_rdy) begin
               ir_wr      = 1'b1;
               pc_wr      = 1'b1;
               pc_src     = PC_PLUS4;
               next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            if (cls.legal) begin
               next_state = S_EXEC;
            end else begin
               illegal    = 1'b1;
               next_state = S_FETCH;
            end
         end
         S_EXEC: begin
            if (cls.rtype) begin
               alu_op     = rtype_alu_op(instr[5:0]);
               next_state = S_WB;
            end else if (cls.itype) begin
               alu_op     = ALU_OR;
               bsel       = 1'b1;
               next_state = S_WB;
            end else if (cls.load || cls.store) begin
               alu_op     = ALU_ADD;
               bsel       = 1'b1;
               next_state = S_MEM;
            end else if (cls.branch) begin
               if (breq) begin
                  pc_wr  = 1'b1;
                  pc_src = PC_BR;
               end
               retire     = 1'b1;
               next_state = S_FETCH;
            end else if (cls.jump) begin
               pc_wr      = 1'b1;
               pc_src     = PC_JUMP;
               reg_wr     = 1'b1;
               wd_sel     = WD_fromPC;
               rd_sel     = RD_RA;
               retire     = 1'b1;
               next_state = S_FETCH;
            end else begin
               next_state = S_FETCH;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dm_wr    = cls.store;
            if (dmem_rdy) begin
               if (cls.store) begin
                  retire     = 1'b1;
                  next_state = S_FETCH;
               end else begin
                  next_state = S_WB;
               end
            end
         end
         S_WB: begin
            reg_wr     = 1'b1;
            wd_sel     = cls.load ? WD_fromMEM : WD_fromALU;
            rd_sel     = cls.rtype ? RD_fromRD : RD_fromRT;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         default: next_state = S_FETCH;
      endcase
      if (rst) begin
         imem_req = 1'b0;
         ir_wr    = 1'b0;
         dmem_req = 1'b0;
         dm_wr    = 1'b0;
         reg_wr   = 1'b0;
         pc_wr    = 1'b0;
         pc_src   = PC_PLUS4;
         bsel     = 1'b0;
         alu_op   = ALU_ADD;
         wd_sel   = WD_fromALU;
         rd_sel   = RD_fromRD;
         illegal  = 1'b0;
         retire   = 1'b0;
      end
   end

`ifdef MC_PERF_CNT_EN
   logic [31:0] cycle_q;
   logic [31:0] instr_q;

   // Free-running cycle counter and retired-instruction counter, both wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (retire) instr_q <= instr_q + 32'd1;
      end
   end

   assign cycle_cnt = cycle_q;
   assign instr_cnt = instr_q;
`else
   logic unused_retire;

   assign unused_retire = retire;
   assign cycle_cnt     = '0;
   assign instr_cnt     = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl. A per-instruction model lists the
// strobes each cycle must show; one compare process checks every cycle.
// Counter expectations follow MC_PERF_CNT_EN in the same way as the design.
module tb_mc_ctrl;
   import mc_ctrl_pkg::*;

   typedef struct packed {
      logic       imem_req;
      logic       ir_wr;
      logic       dmem_req;
      logic       dm_wr;
      logic       reg_wr;
      logic       pc_wr;
      logic [1:0] pc_src;
      logic       bsel;
      logic [1:0] alu_op;
      logic [1:0] wd_sel;
      logic [1:0] rd_sel;
      logic       illegal;
   } outs_t;

   typedef enum {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_JAL, K_ILL} kind_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        breq, imem_rdy, dmem_rdy;
   logic        imem_req, ir_wr, dmem_req, dm_wr, reg_wr, pc_wr, bsel, illegal;
   logic [1:0]  pc_src, alu_op, wd_sel, rd_sel;
   logic [31:0] cycle_cnt, instr_cnt;

   outs_t exp_outs;
   outs_t act_outs;
   logic  exp_valid = 1'b0;
   int    m_cycles = 0;
   int    m_instrs = 0;
   int    vectors = 0;
   int    miscompares = 0;
   int    tally_cycles, tally_dmem, tally_dmwr, tally_regwr, tally_pcwr, tally_illegal;

   always #5 clk = ~clk;

   mc_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .instr     (instr),
      .breq      (breq),
      .imem_rdy  (imem_rdy),
      .dmem_rdy  (dmem_rdy),
      .imem_req  (imem_req),
      .ir_wr     (ir_wr),
      .dmem_req  (dmem_req),
      .dm_wr     (dm_wr),
      .reg_wr    (reg_wr),
      .pc_wr     (pc_wr),
      .pc_src    (pc_src),
      .bsel      (bsel),
      .alu_op    (alu_op),
      .wd_sel    (wd_sel),
      .rd_sel    (rd_sel),
      .illegal   (illegal),
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
   );

   function automatic logic [31:0] exp_cnt(input int v);
`ifdef MC_PERF_CNT_EN
      return v;
`else
      return (v == v) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Single compare point: sample DUT outputs on the falling edge
   always @(negedge clk) begin
      if (exp_valid) begin
         act_outs = '{imem_req, ir_wr, dmem_req, dm_wr, reg_wr, pc_wr, pc_src, bsel,
                      alu_op, wd_sel, rd_sel, illegal};
         checkOutput("strobes", 32'(act_outs), 32'(exp_outs));
         checkOutput("cycle_cnt", cycle_cnt, exp_cnt(m_cycles));
         checkOutput("instr_cnt", instr_cnt, exp_cnt(m_instrs));
         tally_cycles++;
         if (dmem_req) tally_dmem++;
         if (dm_wr) tally_dmwr++;
         if (reg_wr) tally_regwr++;
         if (pc_wr) tally_pcwr++;
         if (illegal) tally_illegal++;
      end
   end

   task automatic clearTallies();
      tally_cycles = 0; tally_dmem = 0; tally_dmwr = 0;
      tally_regwr = 0; tally_pcwr = 0; tally_illegal = 0;
   endtask

   // One clock: publish expectation, advance, then update the counter model
   task automatic step(input outs_t e, input bit retires);
      exp_outs  = e;
      exp_valid = 1'b1;
      @(posedge clk);
      if (rst) begin
         m_cycles = 0;
         m_instrs = 0;
      end else begin
         m_cycles++;
         if (retires) m_instrs++;
      end
      #1;
   endtask

   // Drive one instruction through the controller and state what each cycle must show
   task automatic applyStimulus(input logic [31:0] ins, input kind_t k, input int iw,
                                input int dw, input logic br, input int abort_wait);
      outs_t e;
      instr = ins;
      breq  = br;
      for (int i = 0; i < iw; i++) begin
         imem_rdy = 1'b0; dmem_rdy = 1'b1;
         e = '0; e.imem_req = 1'b1;
         step(e, 1'b0);
      end
      imem_rdy = 1'b1;
      e = '0; e.imem_req = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1; e.pc_src = PC_PLUS4;
      step(e, 1'b0);
      e = '0; e.illegal = (k == K_ILL);
      step(e, 1'b0);
      if (k == K_ILL) return;
      e = '0;
      case (k)
         K_ADDU: e.alu_op = ALU_ADDU;
         K_SUBU: e.alu_op = ALU_SUBU;
         K_ORI:  begin e.alu_op = ALU_OR;  e.bsel = 1'b1; end
         K_LW, K_SW: begin e.alu_op = ALU_ADD; e.bsel = 1'b1; end
         K_BEQ:  if (br) begin e.pc_wr = 1'b1; e.pc_src = PC_BR; end
         K_JAL:  begin
            e.pc_wr = 1'b1; e.pc_src = PC_JUMP; e.reg_wr = 1'b1;
            e.wd_sel = WD_fromPC; e.rd_sel = RD_RA;
         end
         default: e = '0;
      endcase
      step(e, (k == K_BEQ) || (k == K_JAL));
      if ((k == K_BEQ) || (k == K_JAL)) return;
      if ((k == K_LW) || (k == K_SW)) begin
         for (int i = 0; i < dw; i++) begin
            dmem_rdy = 1'b0;
            if (i == abort_wait) begin
               rst = 1'b1;
               e = '0;
               step(e, 1'b0);
               rst = 1'b0;
               return;
            end
            e = '0; e.dmem_req = 1'b1; e.dm_wr = (k == K_SW);
            step(e, 1'b0);
         end
         dmem_rdy = 1'b1;
         e = '0; e.dmem_req = 1'b1; e.dm_wr = (k == K_SW);
         step(e, k == K_SW);
         if (k == K_SW) return;
      end
      e = '0; e.reg_wr = 1'b1;
      e.wd_sel = (k == K_LW) ? WD_fromMEM : WD_fromALU;
      e.rd_sel = ((k == K_ADDU) || (k == K_SUBU)) ? RD_fromRD : RD_fromRT;
      step(e, 1'b1);
   endtask

   // Run bound: a stuck run still reports before stopping
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual timeout required completion");
      $fatal(1, "[TB] run did not complete");
   end

   initial begin
      outs_t z;
      rst = 1'b1; instr = '0; breq = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0;
      clearTallies();
      repeat (2) @(posedge clk);
      #1;
      z = '0;
      step(z, 1'b0);
      imem_rdy = 1'b1; dmem_rdy = 1'b1;
      step(z, 1'b0);
      rst = 1'b0;

      clearTallies();
      applyStimulus(32'h00221821, K_ADDU, 0, 0, 1'b0, -1);
      checkOutput("addu_cycles", tally_cycles, 4);
      checkOutput("addu_regwr", tally_regwr, 1);
      checkOutput("addu_pcwr", tally_pcwr, 1);

      clearTallies();
      applyStimulus(32'h8C220004, K_LW, 0, 3, 1'b0, -1);
      checkOutput("lw_cycles", tally_cycles, 8);
      checkOutput("lw_dmem_req", tally_dmem, 4);
      checkOutput("lw_dm_wr", tally_dmwr, 0);
      checkOutput("lw_regwr", tally_regwr, 1);

      clearTallies();
      applyStimulus(32'h10220004, K_BEQ, 0, 0, 1'b1, -1);
      checkOutput("beq_taken_cycles", tally_cycles, 3);
      checkOutput("beq_taken_pcwr", tally_pcwr, 2);
      clearTallies();
      applyStimulus(32'h10220004, K_BEQ, 0, 0, 1'b0, -1);
      checkOutput("beq_nt_cycles", tally_cycles, 3);
      checkOutput("beq_nt_pcwr", tally_pcwr, 1);

      clearTallies();
      applyStimulus(32'h0C000010, K_JAL, 1, 0, 1'b0, -1);
      checkOutput("jal_cycles", tally_cycles, 4);
      checkOutput("jal_regwr", tally_regwr, 1);
      checkOutput("jal_pcwr", tally_pcwr, 2);

      clearTallies();
      applyStimulus(32'hFC000000, K_ILL, 0, 0, 1'b0, -1);
      checkOutput("ill_cycles", tally_cycles, 2);
      checkOutput("ill_pulse", tally_illegal, 1);
      checkOutput("ill_regwr", tally_regwr, 0);
      checkOutput("ill_pcwr", tally_pcwr, 1);
      applyStimulus(32'h00221820, K_ILL, 0, 0, 1'b0, -1);

      applyStimulus(32'h00221823, K_SUBU, 2, 0, 1'b0, -1);
      applyStimulus(32'h34220005, K_ORI, 0, 0, 1'b0, -1);
      clearTallies();
      applyStimulus(32'hAC220004, K_SW, 0, 0, 1'b0, -1);
      checkOutput("sw_cycles", tally_cycles, 4);
      checkOutput("sw_dm_wr", tally_dmwr, 1);
      applyStimulus(32'h8C220004, K_LW, 1, 1, 1'b0, -1);

      clearTallies();
      applyStimulus(32'hAC220008, K_SW, 0, 3, 1'b0, 1);
      checkOutput("sw_abort_dmem_req", tally_dmem, 1);
      checkOutput("sw_abort_instr_cnt", instr_cnt, 0);
      applyStimulus(32'h00221821, K_ADDU, 2, 0, 1'b0, -1);
      applyStimulus(32'h0C000010, K_JAL, 0, 0, 1'b0, -1);

      exp_valid = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle sequencing controller for the simpleMIPS datapath, covering addu, subu, ori, lw, sw, beq and jal. It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine that issues one-cycle datapath strobes per step. It also handshakes with instruction and data memories that may take several cycles. It sits between the instruction register and the existing datapath muxes, register file, ALU and PC.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  current instruction-register contents.
- breq  in  1  ALU equality flag, valid in EXEC.
- imem_rdy  in  1  instruction memory completes the request this cycle.
- dmem_rdy  in  1  data memory completes the request this cycle.
- imem_req  out  1  instruction fetch request.
- ir_wr  out  1  load IR from instruction memory.
- dmem_req  out  1  data memory request.
- dm_wr  out  1  data memory write; qualifies dmem_req.
- reg_wr  out  1  register file write enable.
- pc_wr  out  1  PC write enable.
- pc_src  out  2  PC source: `PC_PLUS4`, `PC_BR`, `PC_JUMP`.
- bsel  out  1  ALU B operand is the immediate.
- alu_op  out  2  `ALU_ADD`, `ALU_ADDU`, `ALU_SUBU`, `ALU_OR`.
- wd_sel  out  2  `WD_fromALU`, `WD_fromMEM`, `WD_fromPC`.
- rd_sel  out  2  `RD_fromRD`, `RD_fromRT`, `RD_RA`.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- cycle_cnt  out  32  performance counter (see Configuration).
- instr_cnt  out  32  performance counter (see Configuration).

## Operation

**Reset**
- The state register resets to S_FETCH.
- While rst is high, every output except the counters is forced to 0, regardless of state.
- Asserting rst in any state, including mid-handshake, aborts the operation. Requests drop in that same cycle.

**S_FETCH**
- imem_req is high.
- On imem_rdy: assert ir_wr, pc_wr and pc_src=`PC_PLUS4`, then go to S_DECODE.
- Without imem_rdy: hold in S_FETCH.

**S_DECODE**
- One cycle; the datapath latches its register operands.
- A supported instruction goes to S_EXEC.
- Anything else pulses illegal and returns to S_FETCH with no writes.

**S_EXEC**
- alu_op and bsel are driven from instr:
  - R-type: addu gives `ALU_ADDU`, subu gives `ALU_SUBU`.
  - ori gives `ALU_OR` with bsel=1.
  - lw and sw give `ALU_ADD` with bsel=1.
- beq: assert pc_wr with pc_src=`PC_BR` only if breq=1, then go to S_FETCH.
- jal: assert pc_wr with pc_src=`PC_JUMP`, plus reg_wr with wd_sel=`WD_fromPC` and rd_sel=`RD_RA`, then go to S_FETCH.
- R-type and ori go to S_WB.
- lw and sw go to S_MEM.

**S_MEM**
- dmem_req is high; dm_wr=1 for sw.
- Hold in S_MEM until dmem_rdy.
- On dmem_rdy: sw goes to S_FETCH, lw goes to S_WB.

**S_WB**
- Assert reg_wr.
- R-type: wd_sel=`WD_fromALU`, rd_sel=`RD_fromRD`.
- ori: wd_sel=`WD_fromALU`, rd_sel=`RD_fromRT`.
- lw: wd_sel=`WD_fromMEM`, rd_sel=`RD_fromRT`.
- Then go to S_FETCH.

**Output defaults**
- Outputs are combinational from state and instr.
- In any state that does not drive a mux select, that select defaults to encoding 0.
- Strobes are high only in the cycles listed above.

## Timing
- Cycles per instruction with zero-wait memories (rdy high in the first request cycle):
  - beq, jal: 3.
  - R-type, ori, sw: 4.
  - lw: 5.
  - Each memory wait cycle adds 1.
- Request rules:
  - Each req stays high continuously until its rdy is sampled high at a rising edge.
  - A rdy arriving while the matching req is low is ignored.
- ir_wr and the FETCH pc_wr occur in the same cycle as imem_rdy.
- The DECODE→FETCH path after an illegal instruction takes 2 cycles in total.

## Configuration
- `MC_PERF_CNT_EN` defined:
  - cycle_cnt increments every cycle in which rst is low.
  - instr_cnt increments on every retiring transition into S_FETCH (from EXEC, MEM or WB). Illegal instructions are not counted.
  - Both counters wrap modulo 2^32 and reset to 0.
- `MC_PERF_CNT_EN` undefined: both ports are tied to constant 0 and no counter flops exist.

## Structure
- State encodings `S_FETCH`..`S_WB` (3-bit) and the `PC_*` selects go in the shared `defs.vh`.
- `defs.vh` already holds the `OP_*`, `FUNCT_*`, `ALU_*`, `WD_*`, `RD_*` and segment macros; the new constants sit alongside them.
- One combinational sub-module, `mc_decode`, classifies instr into rtype, itype, load, store, branch, jump and legal. The FSM in mc_ctrl consumes those classes.

## Test plan
- addu $3,$1,$2 (0x00221821), memories zero-wait → strobe sequence is:
  - c0 imem_req+ir_wr+pc_wr.
  - c1 decode.
  - c2 alu_op=`ALU_ADDU`.
  - c3 reg_wr with rd_sel=`RD_fromRD`.
  - Back in S_FETCH at c4.
- lw (0x8C220004) with dmem_rdy delayed 3 cycles → dmem_req is high for 4 cycles with dm_wr=0. reg_wr with wd_sel=`WD_fromMEM` follows one cycle after the rdy cycle; total 8 cycles.
- beq with breq=1, then with breq=0 → pc_wr with pc_src=`PC_BR` appears in EXEC only in the breq=1 run; both runs take 3 cycles.
- jal (0x0C000010) → in EXEC, pc_wr with `PC_JUMP` and reg_wr with `RD_RA`/`WD_fromPC` fire in the same cycle.
- Opcode 0x3F → illegal pulses once in DECODE, no reg_wr/dm_wr/pc_wr beyond fetch, and instr_cnt is unchanged.
- rst asserted on the second wait cycle of sw → dmem_req and dm_wr go low that cycle; after release, imem_req rises and the counters read 0.
